// File: rtl/switch_debounce_toggle_if.sv
// Switch debounce/toggle signal bundle.
// Purpose : carries the two raw switch levels into the debouncer and its
//           debounced levels, release pulses and LED drives back out.
// Ports   : i_Switch_1/2     raw, asynchronous, bouncing switch levels (1 = pressed)
//           o_Switch_1/2_Db  debounced switch levels
//           o_Release_1/2    one-clock pulse per accepted release
//           o_LED_1/2        toggles once per accepted release
//           o_LED_3          registered AND of both debounced levels
// Modports: slave  - the debouncer (consumes switches, drives results)
//           master - the switch/board side (drives switches, observes results)
interface switch_debounce_toggle_if;
  logic i_Switch_1;
  logic i_Switch_2;
  logic o_Switch_1_Db;
  logic o_Switch_2_Db;
  logic o_Release_1;
  logic o_Release_2;
  logic o_LED_1;
  logic o_LED_2;
  logic o_LED_3;

  modport slave (
    input  i_Switch_1, i_Switch_2,
    output o_Switch_1_Db, o_Switch_2_Db,
    output o_Release_1, o_Release_2,
    output o_LED_1, o_LED_2, o_LED_3
  );

  modport master (
    output i_Switch_1, i_Switch_2,
    input  o_Switch_1_Db, o_Switch_2_Db,
    input  o_Release_1, o_Release_2,
    input  o_LED_1, o_LED_2, o_LED_3
  );
endinterface

// File: rtl/switch_debounce_toggle.sv
// Two-channel switch debouncer with release-driven LED toggles.
// Purpose : each raw switch is synchronized, then accepted as a new stable
//           level only after it has differed from the current stable level
//           for DEBOUNCE_LIMIT consecutive clocks. An accepted release
//           (1->0) produces a one-clock pulse and toggles that channel's LED.
//           A third LED shows both debounced switches held together.
// Params  : DEBOUNCE_LIMIT  consecutive clocks a changed level must persist (>= 1)
// Ports   : i_Clk  sole clock, rising edge
//           i_Rst  synchronous, active-high reset
//           sw     switch_debounce_toggle_if.slave (switch inputs, debounced
//                  levels, release pulses, LED outputs)
module switch_debounce_toggle #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  switch_debounce_toggle_if.slave        sw
);

  localparam int CNT_W = ($clog2(DEBOUNCE_LIMIT) < 1) ? 1 : $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic led_3_q;

  // Two identical, fully independent channels; channel 0 is switch 1.
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             raw;
    logic             sync_meta;
    logic             sync_lvl;
    logic             stable;
    logic             stable_next;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             release_q;
    logic             led_q;

    assign raw = (ch == 0) ? sw.i_Switch_1 : sw.i_Switch_2;

    // Any clock where the synchronized level matches the stable level
    // restarts the count, so a single bounce throws away partial progress.
    // The count stops at CNT_LAST and acceptance clears it, so it cannot wrap.
    always_comb begin
      cnt_next    = '0;
      stable_next = stable;
      if (sync_lvl != stable) begin
        if (cnt == CNT_LAST) begin
          stable_next = sync_lvl;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    end

    // stable_prev lags stable by one clock so the release pulse and LED
    // toggle land on the edge after the debounced level falls.
    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        sync_meta   <= 1'b0;
        sync_lvl    <= 1'b0;
        cnt         <= '0;
        stable      <= 1'b0;
        stable_prev <= 1'b0;
        release_q   <= 1'b0;
        led_q       <= 1'b0;
      end else begin
        sync_meta   <= raw;
        sync_lvl    <= sync_meta;
        cnt         <= cnt_next;
        stable      <= stable_next;
        stable_prev <= stable;
        release_q   <= stable_prev & ~stable;
        led_q       <= led_q ^ (stable_prev & ~stable);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      led_3_q <= 1'b0;
    end else begin
      led_3_q <= g_chan[0].stable & g_chan[1].stable;
    end
  end

  assign sw.o_Switch_1_Db = g_chan[0].stable;
  assign sw.o_Switch_2_Db = g_chan[1].stable;
  assign sw.o_Release_1   = g_chan[0].release_q;
  assign sw.o_Release_2   = g_chan[1].release_q;
  assign sw.o_LED_1       = g_chan[0].led_q;
  assign sw.o_LED_2       = g_chan[1].led_q;
  assign sw.o_LED_3       = led_3_q;

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Testbench for switch_debounce_toggle with DEBOUNCE_LIMIT = 4.
// Purpose : directed scenarios (press/release latency, bounce rejection,
//           simultaneous presses, reset mid-count, repeated toggling) followed
//           by random hold-length stimulus. A behavioural model decides the
//           debounced level from a window of the last LIMIT synchronized
//           samples and derives pulses/LEDs from the debounced history.
module tb_switch_debounce_toggle;
  localparam int LIMIT = 4;

  logic i_Clk = 1'b0;
  logic i_Rst;

  int checks = 0;
  int errors = 0;

  switch_debounce_toggle_if sw_if ();

  switch_debounce_toggle #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .sw    (sw_if)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model state, one entry per channel (0 = switch 1).
  logic             raw_dly [2][2];
  logic [LIMIT-1:0] win     [2];
  int               filled  [2];
  logic             m_stable[2];
  logic             m_fell  [2];
  logic             m_rel   [2];
  logic             m_led   [2];
  logic             m_led3;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, "/db1"},   sw_if.o_Switch_1_Db, m_stable[0]);
    checkBit({tag, "/db2"},   sw_if.o_Switch_2_Db, m_stable[1]);
    checkBit({tag, "/rel1"},  sw_if.o_Release_1,   m_rel[0]);
    checkBit({tag, "/rel2"},  sw_if.o_Release_2,   m_rel[1]);
    checkBit({tag, "/led1"},  sw_if.o_LED_1,       m_led[0]);
    checkBit({tag, "/led2"},  sw_if.o_LED_2,       m_led[1]);
    checkBit({tag, "/led3"},  sw_if.o_LED_3,       m_led3);
  endtask

  // Drive one clock of stimulus, advance the model across that edge, and
  // compare every output just after the edge.
  task automatic applyStimulus(input logic rst, input logic s1, input logic s2,
                               input string tag);
    logic raw_now [2];
    logic sync_lvl;
    logic new_stable;
    i_Rst = rst;
    sw_if.i_Switch_1 = s1;
    sw_if.i_Switch_2 = s2;
    raw_now[0] = s1;
    raw_now[1] = s2;
    @(posedge i_Clk);
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        raw_dly[ch][0] = 1'b0;
        raw_dly[ch][1] = 1'b0;
        win[ch]        = '0;
        filled[ch]     = 0;
        m_stable[ch]   = 1'b0;
        m_fell[ch]     = 1'b0;
        m_rel[ch]      = 1'b0;
        m_led[ch]      = 1'b0;
      end
      m_led3 = 1'b0;
    end else begin
      m_led3 = m_stable[0] & m_stable[1];
      for (int ch = 0; ch < 2; ch++) begin
        // Level seen by the debouncer is the raw input from two edges back.
        sync_lvl = raw_dly[ch][1];
        win[ch] = {win[ch][LIMIT-2:0], sync_lvl};
        if (filled[ch] < LIMIT) filled[ch]++;
        new_stable = m_stable[ch];
        if (filled[ch] == LIMIT && win[ch] == {LIMIT{~m_stable[ch]}})
          new_stable = ~m_stable[ch];
        m_rel[ch] = m_fell[ch];
        if (m_fell[ch]) m_led[ch] = ~m_led[ch];
        m_fell[ch]   = m_stable[ch] & ~new_stable;
        m_stable[ch] = new_stable;
        raw_dly[ch][1] = raw_dly[ch][0];
        raw_dly[ch][0] = raw_now[ch];
      end
    end
    #1;
    checkOutput(tag);
  endtask

  int   pulses;
  logic led_seq [3];
  logic r1, r2;
  int   hold;

  initial begin
    i_Rst = 1'b1;
    sw_if.i_Switch_1 = 1'b0;
    sw_if.i_Switch_2 = 1'b0;

    applyStimulus(1, 0, 0, "reset");
    applyStimulus(1, 0, 0, "reset");
    applyStimulus(0, 0, 0, "idle");

    // Press switch 1 and hold: accepted after edge k+5, no LED/pulse.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, "press1");
    checkBit("press1_k4_db1", sw_if.o_Switch_1_Db, 1'b0);
    applyStimulus(0, 1, 0, "press1");
    checkBit("press1_k5_db1",  sw_if.o_Switch_1_Db, 1'b1);
    checkBit("press1_k5_led1", sw_if.o_LED_1,       1'b0);
    checkBit("press1_k5_rel1", sw_if.o_Release_1,   1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, "hold1");

    // Release switch 1: level falls after k+5, pulse and toggle after k+6.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "release1");
    checkBit("release1_k4_db1", sw_if.o_Switch_1_Db, 1'b1);
    applyStimulus(0, 0, 0, "release1");
    checkBit("release1_k5_db1",  sw_if.o_Switch_1_Db, 1'b0);
    checkBit("release1_k5_rel1", sw_if.o_Release_1,   1'b0);
    applyStimulus(0, 0, 0, "release1");
    checkBit("release1_k6_rel1", sw_if.o_Release_1, 1'b1);
    checkBit("release1_k6_led1", sw_if.o_LED_1,     1'b1);
    applyStimulus(0, 0, 0, "release1");
    checkBit("release1_k7_rel1", sw_if.o_Release_1, 1'b0);
    checkBit("release1_k7_led1", sw_if.o_LED_1,     1'b1);

    // Switch 2 bouncing every two clocks never gets accepted.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, i[0] ? 1'b0 : 1'b1, "bounce2");
      applyStimulus(0, 0, i[0] ? 1'b0 : 1'b1, "bounce2");
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, "settle");
    checkBit("bounce2_db2",  sw_if.o_Switch_2_Db, 1'b0);
    checkBit("bounce2_led2", sw_if.o_LED_2,       1'b0);

    // Both pressed together: same acceptance edge, LED_3 one edge later.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, "both");
    checkBit("both_k5_db1",  sw_if.o_Switch_1_Db, 1'b1);
    checkBit("both_k5_db2",  sw_if.o_Switch_2_Db, 1'b1);
    checkBit("both_k5_led3", sw_if.o_LED_3,       1'b0);
    applyStimulus(0, 1, 1, "both");
    checkBit("both_k6_led3", sw_if.o_LED_3, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, "rel1only");
    checkBit("rel1only_led3", sw_if.o_LED_3, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, "relboth");

    // Reset at count 2 with switch 1 held: full latency again afterwards.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, "precount");
    applyStimulus(1, 1, 0, "midreset");
    checkBit("midreset_led1", sw_if.o_LED_1, 1'b0);
    checkBit("midreset_led2", sw_if.o_LED_2, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, "postreset");
    checkBit("postreset_n5_db1", sw_if.o_Switch_1_Db, 1'b0);
    applyStimulus(0, 1, 0, "postreset");
    checkBit("postreset_n6_db1",  sw_if.o_Switch_1_Db, 1'b1);
    checkBit("postreset_n6_rel1", sw_if.o_Release_1,   1'b0);
    checkBit("postreset_n6_led1", sw_if.o_LED_1,       1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, "hold1");

    // Three release/press cycles: LED_1 goes 1, 0, 1 with three pulses.
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus(0, 0, 0, "cycle_rel");
        if (sw_if.o_Release_1 === 1'b1) pulses++;
      end
      led_seq[c] = sw_if.o_LED_1;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(0, 1, 0, "cycle_press");
        if (sw_if.o_Release_1 === 1'b1) pulses++;
      end
    end
    checkBit("cycle_led_0", led_seq[0], 1'b1);
    checkBit("cycle_led_1", led_seq[1], 1'b0);
    checkBit("cycle_led_2", led_seq[2], 1'b1);
    checks++;
    assert (pulses === 3) else begin
      errors++;
      $error("[TB] FAIL cycle_pulses: observed %0d expected %0d", pulses, 3);
    end

    // Random hold lengths around the limit, with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      r1   = 1'($urandom_range(0, 1));
      r2   = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 9));
      if ($urandom_range(0, 19) == 0) applyStimulus(1, r1, r2, "rand_rst");
      for (int i = 0; i < hold; i++) applyStimulus(0, r1, r2, "rand");
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_debounce_toggle.md
SWITCH_DEBOUNCE_TOGGLE -- requirements
Module: switch_debounce_toggle

Interface
REQ-001: Parameter DEBOUNCE_LIMIT, default 250000, sets the number of consecutive clocks a changed switch level must persist before acceptance; legal range >= 1.
REQ-002: i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: i_Rst  input  1  reset, synchronous, active-high.
REQ-004: i_Switch_1  input  1  raw, asynchronous, bouncing switch 1 level (1 = pressed).
REQ-005: i_Switch_2  input  1  raw, asynchronous, bouncing switch 2 level (1 = pressed).
REQ-006: o_Switch_1_Db  output  1  debounced level of switch 1.
REQ-007: o_Switch_2_Db  output  1  debounced level of switch 2.
REQ-008: o_Release_1  output  1  one-clock pulse on accepted release (1->0) of switch 1.
REQ-009: o_Release_2  output  1  one-clock pulse on accepted release of switch 2.
REQ-010: o_LED_1  output  1  toggles once per accepted release of switch 1.
REQ-011: o_LED_2  output  1  toggles once per accepted release of switch 2.
REQ-012: o_LED_3  output  1  registered AND of o_Switch_1_Db and o_Switch_2_Db.
REQ-013: One clock (i_Clk); reset i_Rst is synchronous and active-high.

Function
REQ-014: Each switch channel is independent and identical; no shared counter between channels.
REQ-015: Each raw input passes through a two-flop synchronizer before any other logic; the second flop is the channel's sync level.
REQ-016: Each channel holds a stable state register (drives o_Switch_n_Db) and a counter of width max(1, ceil(log2(DEBOUNCE_LIMIT))).
REQ-017: Sync level equal to stable state -> counter cleared to 0 that clock (any bounce restarts the count).
REQ-018: Sync level differs and counter == DEBOUNCE_LIMIT-1 -> stable state takes sync level, counter cleared to 0.
REQ-019: Sync level differs and counter < DEBOUNCE_LIMIT-1 -> counter increments by 1; counter never wraps.
REQ-020: Latency: raw input changed before edge k and held -> o_Switch_n_Db changes after edge k+1+DEBOUNCE_LIMIT.
REQ-021: Pulses shorter than DEBOUNCE_LIMIT clocks at the sync flop produce no change on any output.
REQ-022: o_Release_n is registered: asserted for exactly one clock, on the edge after the stable state goes 1->0; never asserted for a 0->1 acceptance.
REQ-023: o_LED_n inverts on the same edge o_Release_n asserts; a press alone never changes it.
REQ-024: o_LED_3 updates one edge after the debounced levels it is derived from.
REQ-025: Simultaneous acceptances on both channels are each processed in the same clock with no interaction.

Reset
REQ-026: i_Rst high at an edge -> synchronizer flops, stable states, counters, o_Release_1/2, o_LED_1/2/3 all 0 after that edge.
REQ-027: Reset asserted mid-count discards the partial count; after release, a held input needs the full k+1+DEBOUNCE_LIMIT latency again.
REQ-028: Reset has priority over every other update in the same clock.
REQ-029: A switch held pressed through reset is accepted as a press (0->1) after reset deasserts, with no release pulse or LED toggle.

Verification (DEBOUNCE_LIMIT = 4)
REQ-030: Reset, then i_Switch_1 0->1 before edge k and held -> o_Switch_1_Db = 1 after edge k+5, o_LED_1 stays 0, o_Release_1 stays 0.
REQ-031: Switch 1 pressed and accepted, then released and held 0 -> o_Switch_1_Db = 0 after edge k+5, o_Release_1 = 1 for exactly the clock after edge k+6, o_LED_1 = 1.
REQ-032: i_Switch_2 toggling every 2 clocks for 40 clocks (bounce) -> o_Switch_2_Db, o_Release_2, o_LED_2 unchanged throughout.
REQ-033: Both switches pressed on the same clock and held -> both debounced outputs rise after the same edge, o_LED_3 = 1 one edge later; releasing switch 1 only -> o_LED_3 returns to 0.
REQ-034: Switch 1 pressed, i_Rst pulsed for 1 clock at counter = 2, switch still held -> all outputs 0 after reset edge; o_Switch_1_Db rises only 6 edges after reset deasserts.
REQ-035: Three full press/release cycles on switch 1 -> o_LED_1 sequence 1, 0, 1; exactly three o_Release_1 pulses.
